// File: rtl/axi_port_fifo.sv
// FIFO endpoint for one bridge user port: AXI writes feed a TX stream FIFO, fabric RX stream feeds AXI reads.
// The bus is never stalled; overflowing writes and underrunning reads complete with an error flag.
module axi_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              S00_AXI_aclk,
  input  logic              S00_AXI_aresetn,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic              werror_o,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rerror_o,
  output logic              tx_tvalid_o,
  input  logic              tx_tready_i,
  output logic [DATA_W-1:0] tx_tdata_o,
  input  logic              rx_tvalid_i,
  output logic              rx_tready_o,
  input  logic [DATA_W-1:0] rx_tdata_i,
  output logic [AW:0]       tx_level_o,
  output logic [AW:0]       rx_level_o,
  output logic [CNT_W-1:0]  tx_drop_cnt_o,
  output logic [CNT_W-1:0]  rx_unrun_cnt_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_wr, tx_rd, rx_wr, rx_rd;
  logic [AW:0]       tx_count, rx_count;
  logic [CNT_W-1:0]  tx_drop, rx_unrun;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_drop_ev, rx_push, rx_pop, rx_unrun_ev;

  // Full/empty come from the pre-edge count, so a same-cycle pop never frees room for a push.
  assign tx_full     = (tx_count == FULL_LVL);
  assign tx_empty    = (tx_count == '0);
  assign rx_full     = (rx_count == FULL_LVL);
  assign rx_empty    = (rx_count == '0);

  assign tx_push     = wvalid_i & ~tx_full;
  assign tx_drop_ev  = wvalid_i & tx_full;
  assign tx_pop      = ~tx_empty & tx_tready_i;
  assign rx_push     = rx_tvalid_i & ~rx_full;
  assign rx_pop      = rready_i & ~rx_empty;
  assign rx_unrun_ev = rready_i & rx_empty;

  assign wready_o       = 1'b1;
  assign werror_o       = tx_full;
  assign rvalid_o       = 1'b1;
  assign rerror_o       = rx_empty;
  assign rdata_o        = rx_empty ? '0 : rx_mem[rx_rd];
  assign tx_tvalid_o    = ~tx_empty;
  assign tx_tdata_o     = tx_mem[tx_rd];
  assign rx_tready_o    = ~rx_full;
  assign tx_level_o     = tx_count;
  assign rx_level_o     = rx_count;
  assign tx_drop_cnt_o  = tx_drop;
  assign rx_unrun_cnt_o = rx_unrun;

  always_ff @(posedge S00_AXI_aclk) begin
    if (tx_push) tx_mem[tx_wr] <= wdata_i;
    if (rx_push) rx_mem[rx_wr] <= rx_tdata_i;
  end

  always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
    if (!S00_AXI_aresetn) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      tx_drop  <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + (AW+1)'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - (AW+1)'(1);
      if (tx_drop_ev && (tx_drop != '1)) tx_drop <= tx_drop + CNT_W'(1);
    end
  end

  always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
    if (!S00_AXI_aresetn) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
      rx_unrun <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + (AW+1)'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - (AW+1)'(1);
      if (rx_unrun_ev && (rx_unrun != '1)) rx_unrun <= rx_unrun + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_port_fifo.sv
// Directed bench for axi_port_fifo: TX ordering/overflow, RX ordering across wraps, reset flush, counter saturation.
module tb_axi_port_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 4;
  localparam int AW     = $clog2(DEPTH);

  logic              clk, rst_n;
  logic              wvalid, wready, werror;
  logic [DATA_W-1:0] wdata;
  logic              rvalid, rready, rerror;
  logic [DATA_W-1:0] rdata;
  logic              tx_tvalid, tx_tready;
  logic [DATA_W-1:0] tx_tdata;
  logic              rx_tvalid, rx_tready;
  logic [DATA_W-1:0] rx_tdata;
  logic [AW:0]       tx_level, rx_level;
  logic [CNT_W-1:0]  tx_drop_cnt, rx_unrun_cnt;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_word;
  logic [CNT_W-1:0]  exp_unrun;
  int total = 0;
  int bad   = 0;

  axi_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .S00_AXI_aclk(clk), .S00_AXI_aresetn(rst_n),
    .wvalid_i(wvalid), .wready_o(wready), .werror_o(werror), .wdata_i(wdata),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rerror_o(rerror),
    .tx_tvalid_o(tx_tvalid), .tx_tready_i(tx_tready), .tx_tdata_o(tx_tdata),
    .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready), .rx_tdata_i(rx_tdata),
    .tx_level_o(tx_level), .rx_level_o(rx_level),
    .tx_drop_cnt_o(tx_drop_cnt), .rx_unrun_cnt_o(rx_unrun_cnt)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked 1 ns later, well before the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wvalid = 1'b0; wdata = '0; rready = 1'b0;
    tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0;
    exp_unrun = '0;
    repeat (3) step();
    rst_n = 1'b1;
    settle();

    // 1. reset state and a single underrun read
    check("rst_tx_level", 32'(tx_level), 0);
    check("rst_rx_level", 32'(rx_level), 0);
    check("rst_tx_tvalid", 32'(tx_tvalid), 0);
    check("rst_rx_tready", 32'(rx_tready), 1);
    check("rst_werror", 32'(werror), 0);
    check("rst_wready", 32'(wready), 1);
    check("rst_rvalid", 32'(rvalid), 1);
    rready = 1'b1;
    settle();
    check("t1_rerror", 32'(rerror), 1);
    check("t1_rdata", rdata, 0);
    step();
    rready = 1'b0;
    exp_unrun = 4'd1;
    settle();
    check("t1_unrun_cnt", 32'(rx_unrun_cnt), 32'(exp_unrun));

    // 2. three writes held, then drained in order
    for (int i = 1; i <= 3; i++) begin
      wvalid = 1'b1; wdata = 32'hA5A5_0000 + 32'(i);
      settle();
      check("t2_werror", 32'(werror), 0);
      exp_q.push_back(wdata);
      step();
    end
    wvalid = 1'b0;
    settle();
    check("t2_tx_level", 32'(tx_level), 3);
    tx_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      exp_word = exp_q.pop_front();
      check("t2_tx_tvalid", 32'(tx_tvalid), 1);
      check("t2_tx_tdata", tx_tdata, exp_word);
      step();
    end
    settle();
    check("t2_tx_tvalid_end", 32'(tx_tvalid), 0);
    check("t2_tx_level_end", 32'(tx_level), 0);
    tx_tready = 1'b0;

    // 3. 17 writes into a 16-deep TX with no drain
    for (int i = 0; i < 17; i++) begin
      wvalid = 1'b1; wdata = 32'hC0DE_0000 + 32'(i);
      settle();
      if (i < 16) begin
        check("t3_werror_ok", 32'(werror), 0);
        exp_q.push_back(wdata);
      end else begin
        check("t3_werror_full", 32'(werror), 1);
      end
      step();
    end
    wvalid = 1'b0;
    settle();
    check("t3_drop_cnt", 32'(tx_drop_cnt), 1);
    check("t3_tx_level", 32'(tx_level), 16);

    // 4. write while full with a same-cycle pop: write dropped, pop proceeds
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; tx_tready = 1'b1;
    settle();
    check("t4_werror", 32'(werror), 1);
    exp_word = exp_q.pop_front();
    check("t4_tx_tdata", tx_tdata, exp_word);
    step();
    wvalid = 1'b0; tx_tready = 1'b0;
    settle();
    check("t4_tx_level", 32'(tx_level), 15);
    check("t4_drop_cnt", 32'(tx_drop_cnt), 2);

    // 3 (cont). drain the remaining original words
    tx_tready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      settle();
      exp_word = exp_q.pop_front();
      check("t3_drain_tdata", tx_tdata, exp_word);
      step();
    end
    settle();
    check("t3_drain_tvalid_end", 32'(tx_tvalid), 0);
    tx_tready = 1'b0;

    // 5. 40 RX words, each read back the cycle after its push
    for (int i = 0; i < 40; i++) begin
      rx_tvalid = 1'b1; rx_tdata = 32'h5000_0000 + 32'(i * 7);
      exp_q.push_back(rx_tdata);
      settle();
      check("t5_rx_tready", 32'(rx_tready), 1);
      step();
      rx_tvalid = 1'b0; rready = 1'b1;
      settle();
      exp_word = exp_q.pop_front();
      check("t5_rerror", 32'(rerror), 0);
      check("t5_rdata", rdata, exp_word);
      step();
      rready = 1'b0;
    end
    settle();
    check("t5_rx_level", 32'(rx_level), 0);

    // 6. five RX words, then a one-cycle reset while the stream is still offering
    for (int i = 0; i < 5; i++) begin
      rx_tvalid = 1'b1; rx_tdata = 32'h6000_0000 + 32'(i);
      step();
    end
    settle();
    check("t6_rx_level_pre", 32'(rx_level), 5);
    rst_n = 1'b0;
    settle();
    check("t6_rx_level", 32'(rx_level), 0);
    check("t6_tx_level", 32'(tx_level), 0);
    check("t6_drop_cnt", 32'(tx_drop_cnt), 0);
    check("t6_unrun_cnt", 32'(rx_unrun_cnt), 0);
    check("t6_rx_tready", 32'(rx_tready), 1);
    step();
    rst_n = 1'b1; rx_tvalid = 1'b0; exp_q.delete(); exp_unrun = '0;
    // underrun read with a same-cycle push: read fails, push lands
    rready = 1'b1; rx_tvalid = 1'b1; rx_tdata = 32'h7777_0001;
    settle();
    check("t6_rerror", 32'(rerror), 1);
    check("t6_rdata", rdata, 0);
    step();
    exp_unrun = 4'd1;
    rx_tvalid = 1'b0;
    settle();
    check("t6_push_lands_level", 32'(rx_level), 1);
    check("t6_read_after", rdata, 32'h7777_0001);
    step();
    rready = 1'b0;
    settle();
    check("t6_rx_level_end", 32'(rx_level), 0);

    // 7. 2^CNT_W+3 underrun reads saturate the counter
    rready = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      step();
      exp_unrun = (exp_unrun == '1) ? exp_unrun : exp_unrun + 4'd1;
      settle();
      check("t7_unrun_cnt", 32'(rx_unrun_cnt), 32'(exp_unrun));
    end
    rready = 1'b0;
    settle();
    check("t7_unrun_sat", 32'(rx_unrun_cnt), 32'hF);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
